// File: rtl/dmi_cdc_slave.sv
// dmi_cdc_slave
//   DM-clock side of the DMI clock-domain crossing. Requests arrive from the
//   JTAG domain as a 4-phase req/ack handshake carrying a packed
//   {addr, data, op} word. Read and write requests are forwarded to the debug
//   module on a valid/ready channel. The DM response (or a locally generated
//   response for nop and reserved ops) goes back over a second 4-phase
//   resp/ack handshake.
//
// Ports
//   clk, rst_n                        DM core clock, async active-low reset
//   dtm_req_i, dtm_req_data_i         request level + packet (JTAG domain)
//   dm_ack_o                          request acknowledge to JTAG domain
//   dm_resp_o, dm_resp_data_o         response level + packet to JTAG domain
//   dtm_ack_i                         response acknowledge (JTAG domain)
//   dmi_req_valid_o/ready_i/addr_o/data_o/op_o   request to debug module
//   dmi_rsp_valid_i/data_i/resp_i/ready_o        response from debug module
module dmi_cdc_slave #(
  parameter int DMI_ADDR_BITS = 6,
  parameter int DMI_DATA_BITS = 32,
  parameter int DMI_OP_BITS   = 2,
  parameter int SYNC_STAGES   = 2,
  localparam int W = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dtm_req_i,
  input  logic [W-1:0]             dtm_req_data_i,
  output logic                     dm_ack_o,
  output logic                     dm_resp_o,
  output logic [W-1:0]             dm_resp_data_o,
  input  logic                     dtm_ack_i,
  output logic                     dmi_req_valid_o,
  input  logic                     dmi_req_ready_i,
  output logic [DMI_ADDR_BITS-1:0] dmi_req_addr_o,
  output logic [DMI_DATA_BITS-1:0] dmi_req_data_o,
  output logic [DMI_OP_BITS-1:0]   dmi_req_op_o,
  input  logic                     dmi_rsp_valid_i,
  input  logic [DMI_DATA_BITS-1:0] dmi_rsp_data_i,
  input  logic [DMI_OP_BITS-1:0]   dmi_rsp_resp_i,
  output logic                     dmi_rsp_ready_o
);

  localparam logic [DMI_OP_BITS-1:0] OP_NOP     = DMI_OP_BITS'(0);
  localparam logic [DMI_OP_BITS-1:0] OP_READ    = DMI_OP_BITS'(1);
  localparam logic [DMI_OP_BITS-1:0] OP_WRITE   = DMI_OP_BITS'(2);
  localparam logic [DMI_OP_BITS-1:0] RSP_FAILED = DMI_OP_BITS'(2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DM_REQ    = 3'd1,
    DM_WAIT   = 3'd2,
    RESP      = 3'd3,
    RESP_DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] req_sync, ack_sync;
  logic                   req_s, ack_s;
  logic [W-1:0]           req_q, resp_q;
  logic                   capture;

  logic [DMI_ADDR_BITS-1:0] in_addr;
  logic [DMI_OP_BITS-1:0]   in_op;

  // Synchronizer stage: the only path for the two asynchronous handshake levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync <= '0;
      ack_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], dtm_req_i};
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], dtm_ack_i};
    end
  end

  assign req_s = req_sync[SYNC_STAGES-1];
  assign ack_s = ack_sync[SYNC_STAGES-1];

  assign in_addr = dtm_req_data_i[W-1 -: DMI_ADDR_BITS];
  assign in_op   = dtm_req_data_i[DMI_OP_BITS-1:0];

  // A new request is taken only once the previous one's ack has been withdrawn
  assign capture = (state_q == IDLE) && req_s && !dm_ack_o;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          if (in_op == OP_READ || in_op == OP_WRITE) state_d = DM_REQ;
          else                                       state_d = RESP;
        end
      end
      DM_REQ:    if (dmi_req_ready_i) state_d = DM_WAIT;
      DM_WAIT:   if (dmi_rsp_valid_i) state_d = RESP;
      RESP:      if (ack_s)           state_d = RESP_DONE;
      RESP_DONE: if (!ack_s)          state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    dmi_req_valid_o = 1'b0;
    dmi_rsp_ready_o = 1'b0;
    dm_resp_o       = 1'b0;
    case (state_q)
      DM_REQ:  dmi_req_valid_o = 1'b1;
      DM_WAIT: dmi_rsp_ready_o = 1'b1;
      RESP:    dm_resp_o       = 1'b1;
      default: ;
    endcase
  end

  // Request/response registers and request acknowledge. The ack clears on
  // req_s low regardless of FSM state so the two handshakes run independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= '0;
      resp_q   <= '0;
      dm_ack_o <= 1'b0;
    end else begin
      if (!req_s)       dm_ack_o <= 1'b0;
      else if (capture) dm_ack_o <= 1'b1;

      if (capture) begin
        req_q <= dtm_req_data_i;
        // nop and reserved ops are answered locally without a DM access
        if (in_op == OP_NOP)
          resp_q <= {in_addr, {DMI_DATA_BITS{1'b0}}, OP_NOP};
        else if (in_op != OP_READ && in_op != OP_WRITE)
          resp_q <= {in_addr, {DMI_DATA_BITS{1'b0}}, RSP_FAILED};
      end

      if (state_q == DM_WAIT && dmi_rsp_valid_i)
        resp_q <= {dmi_req_addr_o, dmi_rsp_data_i, dmi_rsp_resp_i};
    end
  end

  assign dmi_req_addr_o = req_q[W-1 -: DMI_ADDR_BITS];
  assign dmi_req_data_o = req_q[DMI_OP_BITS +: DMI_DATA_BITS];
  assign dmi_req_op_o   = req_q[DMI_OP_BITS-1:0];
  assign dm_resp_data_o = resp_q;

endmodule

// File: doc/dmi_cdc_slave.md
DMI_CDC_SLAVE -- requirements
Module: dmi_cdc_slave

Interface
REQ-001 Parameters, SHALL be: DMI_ADDR_BITS, 6, address width; DMI_DATA_BITS, 32, data width; DMI_OP_BITS, 2, op/status width; SYNC_STAGES, 2, synchronizer depth (minimum 2).
REQ-002 Packet width W = DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS; packing SHALL be {addr[MSBs], data, op[1:0] LSBs} for request and response.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, DM core clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- dtm_req_i, in, 1, request level from JTAG-clock domain (asynchronous).
- dtm_req_data_i, in, W, request packet, stable while dtm_req_i high.
- dm_ack_o, out, 1, request acknowledge to JTAG domain.
- dm_resp_o, out, 1, response level to JTAG domain.
- dm_resp_data_o, out, W, response packet, stable while dm_resp_o high.
- dtm_ack_i, in, 1, response acknowledge from JTAG domain (asynchronous).
- dmi_req_valid_o, out, 1, DM request valid.
- dmi_req_ready_i, in, 1, DM accepts request.
- dmi_req_addr_o, out, DMI_ADDR_BITS, DM address.
- dmi_req_data_o, out, DMI_DATA_BITS, DM write data.
- dmi_req_op_o, out, DMI_OP_BITS, 1=read, 2=write.
- dmi_rsp_valid_i, in, 1, DM response valid.
- dmi_rsp_data_i, in, DMI_DATA_BITS, DM read data.
- dmi_rsp_resp_i, in, DMI_OP_BITS, 0=ok, 2=failed, 3=busy.
- dmi_rsp_ready_o, out, 1, block accepts DM response.

Function
REQ-004 dtm_req_i and dtm_ack_i SHALL each pass through a SYNC_STAGES-flop synchronizer (req_s, ack_s); no other async input used combinationally.
REQ-005 FSM states SHALL be IDLE, DM_REQ, DM_WAIT, RESP, RESP_DONE.
REQ-006 IDLE: when req_s=1 and dm_ack_o=0, capture dtm_req_data_i into req register, set dm_ack_o; next state by op: 1/2 -> DM_REQ; 0 (nop) -> RESP with response {addr, 0, 0}; 3 -> RESP with response {addr, 0, 2}.
REQ-007 dm_ack_o SHALL clear on first clk edge where req_s=0; a new capture SHALL NOT occur until dm_ack_o=0.
REQ-008 DM_REQ: dmi_req_valid_o=1 with addr/data/op from req register; on valid&ready -> DM_WAIT; fields SHALL be stable while valid&!ready.
REQ-009 DM_WAIT: dmi_rsp_ready_o=1; on dmi_rsp_valid_i capture {req addr, dmi_rsp_data_i, dmi_rsp_resp_i} into response register -> RESP. dmi_rsp_ready_o SHALL be 0 in all other states.
REQ-010 RESP: dm_resp_o=1; dm_resp_data_o driven from response register, unchanged until next capture; on ack_s=1 -> RESP_DONE.
REQ-011 RESP_DONE: dm_resp_o=0; on ack_s=0 -> IDLE.
REQ-012 Latency: with dtm_req_i high and SYNC_STAGES=2, dm_ack_o and dmi_req_valid_o SHALL rise on the 3rd rising clk edge; dm_resp_o SHALL rise 1 edge after DM response capture.
REQ-013 dmi_rsp_valid_i outside DM_WAIT SHALL be ignored; dtm_ack_i high outside RESP/RESP_DONE SHALL be ignored.
REQ-014 dm_ack_o clear and RESP/RESP_DONE progress SHALL be independent; simultaneous req_s fall and ack_s rise handled in the same cycle.
REQ-015 Request data SHALL be sampled only in IDLE capture; later changes on dtm_req_data_i SHALL have no effect.

Reset
REQ-016 On rst_n low, asynchronously: state IDLE; synchronizer flops, dm_ack_o, dm_resp_o, dmi_req_valid_o, dmi_rsp_ready_o = 0; req/response registers = 0 (dm_resp_data_o=0, dmi_req_* = 0).
REQ-017 Reset asserted mid-transaction SHALL abort it without emitting a response; after release the block SHALL accept the next request only once req_s is seen high.

Verification
REQ-018 Read: req {addr 0x11, data 0, op 1}; DM ready immediate, rsp data 0xDEADBEEF resp 0 -> dmi_req_addr_o=0x11 op=1; dm_resp_data_o={0x11,0xDEADBEEF,0}; full 4-phase on both sides completes to IDLE.
REQ-019 Write with backpressure: op 2, addr 0x10, data 0x00000001, dmi_req_ready_i low 5 cycles -> valid held, fields stable; response resp 0 echoed with addr 0x10.
REQ-020 Nop and reserved: op 0 -> no dmi_req_valid_o, response {addr,0,0}; op 3 -> no DM access, response op field 2.
REQ-021 Latency/sync: dtm_req_i rises between edges -> dm_ack_o high exactly at 3rd edge; dm_ack_o drops within 3 edges of dtm_req_i fall; second request blocked until dm_ack_o=0.
REQ-022 Reset mid-DM_WAIT: rst_n low 2 cycles -> all outputs 0, late dmi_rsp_valid_i ignored; subsequent read completes normally.
REQ-023 Stray inputs: dmi_rsp_valid_i in IDLE and dtm_ack_i high in IDLE -> no state change, outputs unchanged.
